// File: rtl/lvds_tx_link_ctrl.sv
// Link bring-up sequencer and RGB888-to-7:1 lane-word mapper for the LVDS transmit path.
// Define LVDS_TX_JEIDA_EN for the JEIDA bit mapping; the default build uses VESA.
module lvds_tx_link_ctrl #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SER_RST_CYCLES     = 16
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       vs_in,
  input  logic       hs_in,
  input  logic       de_in,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       ser_reset,
  output logic [6:0] data0,
  output logic [6:0] data1,
  output logic [6:0] data2,
  output logic [6:0] data3,
  output logic       link_up,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned LCW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned RCW = $clog2(SER_RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_SER_RST,
    S_BLANK,
    S_ACTIVE
  } state_t;

  state_t           state, state_nxt;
  logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
  logic [RCW-1:0]   rst_cnt, rst_cnt_nxt;
  logic [7:0]       loss_nxt;
  logic             vs_d;
  logic             lock_lost;
  logic [6:0]       word0, word1, word2, word3;

  // Pixel-to-lane mapping; registered only when the link is (about to be) active.
  always_comb begin
`ifdef LVDS_TX_JEIDA_EN
    word0 = {g_in[2], r_in[7:2]};
    word1 = {b_in[3:2], g_in[7:3]};
    word2 = {de_in, vs_in, hs_in, b_in[7:4]};
    word3 = {1'b0, b_in[1:0], g_in[1:0], r_in[1:0]};
`else
    word0 = {g_in[0], r_in[5:0]};
    word1 = {b_in[1:0], g_in[5:1]};
    word2 = {de_in, vs_in, hs_in, b_in[5:2]};
    word3 = {1'b0, b_in[7:6], g_in[7:6], r_in[7:6]};
`endif
  end

  // Next-state logic; losing lock past WAIT_LOCK overrides every other transition.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = '0;
    rst_cnt_nxt  = '0;
    loss_nxt     = lock_loss_cnt;
    lock_lost    = !pll_lock && (state == S_SER_RST || state == S_BLANK || state == S_ACTIVE);

    if (lock_lost) begin
      state_nxt = S_WAIT_LOCK;
      if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
    end else begin
      case (state)
        S_RESET: state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (pll_lock) begin
            if (lock_cnt == LCW'(LOCK_STABLE_CYCLES - 1)) state_nxt = S_SER_RST;
            else lock_cnt_nxt = lock_cnt + LCW'(1);
          end
        end
        S_SER_RST: begin
          if (rst_cnt == RCW'(SER_RST_CYCLES - 1)) state_nxt = S_BLANK;
          else rst_cnt_nxt = rst_cnt + RCW'(1);
        end
        S_BLANK:  if (vs_in && !vs_d) state_nxt = S_ACTIVE;
        S_ACTIVE: state_nxt = S_ACTIVE;
        default:  state_nxt = S_RESET;
      endcase
    end
  end

  // State, counters and all outputs move together so link_up and data stay aligned.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state         <= S_RESET;
      lock_cnt      <= '0;
      rst_cnt       <= '0;
      vs_d          <= 1'b1;
      ser_reset     <= 1'b1;
      link_up       <= 1'b0;
      lock_loss_cnt <= '0;
      data0         <= '0;
      data1         <= '0;
      data2         <= '0;
      data3         <= '0;
    end else begin
      state         <= state_nxt;
      lock_cnt      <= lock_cnt_nxt;
      rst_cnt       <= rst_cnt_nxt;
      vs_d          <= vs_in;
      lock_loss_cnt <= loss_nxt;
      ser_reset     <= (state_nxt == S_RESET) || (state_nxt == S_WAIT_LOCK) ||
                       (state_nxt == S_SER_RST);
      link_up       <= (state_nxt == S_ACTIVE);
      if (state_nxt == S_ACTIVE) begin
        data0 <= word0;
        data1 <= word1;
        data2 <= word2;
        data3 <= word3;
      end else begin
        data0 <= '0;
        data1 <= '0;
        data2 <= '0;
        data3 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lvds_tx_link_ctrl.sv
// Directed bench for lvds_tx_link_ctrl: bring-up timing, frame alignment, mapping, lock loss and saturation.
module tb_lvds_tx_link_ctrl;

  logic       sclk = 1'b0;
  logic       reset, pll_lock, vs_in, hs_in, de_in;
  logic [7:0] r_in, g_in, b_in;
  logic       ser_reset, link_up;
  logic [6:0] data0, data1, data2, data3;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  lvds_tx_link_ctrl #(
    .LOCK_STABLE_CYCLES(8),
    .SER_RST_CYCLES    (4)
  ) dut (
    .sclk         (sclk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .vs_in        (vs_in),
    .hs_in        (hs_in),
    .de_in        (de_in),
    .r_in         (r_in),
    .g_in         (g_in),
    .b_in         (b_in),
    .ser_reset    (ser_reset),
    .data0        (data0),
    .data1        (data1),
    .data2        (data2),
    .data3        (data3),
    .link_up      (link_up),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    check({tag, "_d0"}, 32'(data0), 32'(e0));
    check({tag, "_d1"}, 32'(data1), 32'(e1));
    check({tag, "_d2"}, 32'(data2), 32'(e2));
    check({tag, "_d3"}, 32'(data3), 32'(e3));
  endtask

  task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic de, input logic vs, input logic hs);
    r_in = r; g_in = g; b_in = b; de_in = de; vs_in = vs; hs_in = hs;
  endtask

  // Counts sampled cycles with ser_reset high, bounded so a stuck link cannot hang the run.
  task automatic count_high(output int n);
    n = 0;
    while (ser_reset === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int timeouts;
    timeouts = 0;
    reset    = 1'b1;
    pll_lock = 1'b1;
    set_pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check("rst_ser_reset", 32'(ser_reset), 32'd1);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check_words("rst", 7'h00, 7'h00, 7'h00, 7'h00);

    // Bring-up with steady lock and vs_in already high at BLANK entry
    reset = 1'b0;
    count_high(n);
    check("bringup_ser_reset_cycles", 32'(n), 32'd13);
    check("bringup_link_up", 32'(link_up), 32'd0);
    check_words("bringup", 7'h00, 7'h00, 7'h00, 7'h00);
    repeat (3) step();
    check("vs_level_no_active", 32'(link_up), 32'd0);
    vs_in = 1'b0;
    repeat (2) step();
    check("vs_low_no_active", 32'(link_up), 32'd0);
    check_words("blank", 7'h00, 7'h00, 7'h00, 7'h00);

    // vs rise: first mapped word and link_up together
    set_pix(8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b1, 1'b0);
    step();
    check("vs_rise_link_up", 32'(link_up), 32'd1);
    check("vs_rise_data2_vs", 32'(data2[5]), 32'd1);
    check("active_ser_reset", 32'(ser_reset), 32'd0);
`ifdef LVDS_TX_JEIDA_EN
    check_words("map_a5_3c_f0", 7'h69, 7'h07, 7'h6F, 7'h01);
`else
    check_words("map_a5_3c_f0", 7'h25, 7'h1E, 7'h6C, 7'h32);
`endif
    set_pix(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    check_words("map_red_hs", 7'h3F, 7'h00, 7'h10, 7'h03);
    set_pix(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    check_words("map_green_de", 7'h40, 7'h1F, 7'h40, 7'h0C);

    // One-cycle lock drop in ACTIVE
    vs_in    = 1'b1;
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    check("loss_ser_reset", 32'(ser_reset), 32'd1);
    check("loss_link_up", 32'(link_up), 32'd0);
    check("loss_cnt_1", 32'(lock_loss_cnt), 32'd1);
    check_words("loss", 7'h00, 7'h00, 7'h00, 7'h00);
    count_high(n);
    check("relock_ser_reset_cycles", 32'(n), 32'd12);
    check("relock_blank_link_up", 32'(link_up), 32'd0);

    // Loss from BLANK, then a glitch in WAIT_LOCK at lock_cnt=5
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    check("loss_cnt_2", 32'(lock_loss_cnt), 32'd2);
    repeat (5) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    count_high(n);
    check("glitch_restart_cycles", 32'(n), 32'd12);
    check("glitch_loss_cnt_same", 32'(lock_loss_cnt), 32'd2);

    // Lock loss and vs edge on the same BLANK cycle
    vs_in = 1'b0;
    step();
    vs_in    = 1'b1;
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    check("prio_link_up", 32'(link_up), 32'd0);
    check("prio_ser_reset", 32'(ser_reset), 32'd1);
    check("prio_loss_cnt", 32'(lock_loss_cnt), 32'd3);
    check("prio_data2", 32'(data2), 32'd0);

    // 300 further losses from BLANK
    for (int i = 0; i < 300; i++) begin
      count_high(n);
      if (n >= 200) timeouts++;
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
    end
    check("sat_wait_timeouts", 32'(timeouts), 32'd0);
    check("sat_loss_cnt", 32'(lock_loss_cnt), 32'd255);

    // One-cycle reset mid-operation
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check("rst2_ser_reset", 32'(ser_reset), 32'd1);
    check("rst2_link_up", 32'(link_up), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
